// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: buffers host payload, then sends header, payload, parity.
// Header appears one cycle after an accepted start; bus holds while busy, optional stall-timeout abort.
module router_pkt_tx #(
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 0
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       ld_en,
   input  logic [7:0] ld_data,
   output logic       ld_rdy,
   input  logic       start,
   input  logic [1:0] dest_addr,
   input  logic       busy,
   output logic [7:0] data_out,
   output logic       pkt_valid,
   output logic       tx_active,
   output logic       tx_done,
   output logic       start_err,
   output logic       tx_abort
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_HEADER  = 3'd1;
   localparam logic [2:0] S_PAYLOAD = 3'd2;
   localparam logic [2:0] S_PARITY  = 3'd3;
   localparam logic [2:0] S_GAP     = 3'd4;

   localparam logic [7:0]  GAP_M1 = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
   localparam logic [15:0] TO_M1  = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

   logic [7:0]  mem [64];
   logic [2:0]  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [5:0]  rd_ptr_q, rd_ptr_d;
   logic [5:0]  len_q, len_d;
   logic [7:0]  parity_q, parity_d;
   logic [7:0]  data_q, data_d;
   logic        vld_q, vld_d;
   logic [15:0] stall_q, stall_d;
   logic [7:0]  gap_q, gap_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        abort_q, abort_d;
   logic        wr_en;
   logic        start_ok;
   logic        xfer;

   assign xfer      = !busy;
   assign tx_active = (state_q == S_HEADER) || (state_q == S_PAYLOAD) || (state_q == S_PARITY);
   assign ld_rdy    = (state_q == S_IDLE) && (cnt_q != 6'd63);
   assign start_ok  = (state_q == S_IDLE) && start && (dest_addr != 2'd3) && (cnt_q != 6'd0);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_ptr_d = rd_ptr_q;
      len_d    = len_q;
      parity_d = parity_q;
      data_d   = data_q;
      vld_d    = vld_q;
      stall_d  = stall_q;
      gap_d    = gap_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      abort_d  = 1'b0;
      wr_en    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               len_d    = cnt_q;
               parity_d = {cnt_q, dest_addr};
               data_d   = {cnt_q, dest_addr};
               vld_d    = 1'b1;
               stall_d  = 16'd0;
               state_d  = S_HEADER;
            end else if (start) begin
               err_d = 1'b1;
            end
            // An accepted start freezes the buffer, so a same-cycle load is dropped.
            if (ld_en && ld_rdy && !start_ok) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + 6'd1;
            end
         end
         S_HEADER: begin
            if (xfer) begin
               data_d   = mem[0];
               rd_ptr_d = 6'd0;
               state_d  = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (xfer) begin
               parity_d = parity_q ^ data_q;
               if (rd_ptr_q == len_q - 6'd1) begin
                  data_d  = parity_q ^ data_q;
                  vld_d   = 1'b0;
                  state_d = S_PARITY;
               end else begin
                  rd_ptr_d = rd_ptr_q + 6'd1;
                  data_d   = mem[rd_ptr_q + 6'd1];
               end
            end
         end
         S_PARITY: begin
            if (xfer) begin
               data_d   = 8'd0;
               done_d   = 1'b1;
               cnt_d    = 6'd0;
               rd_ptr_d = 6'd0;
               gap_d    = 8'd0;
               state_d  = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            if (gap_q == GAP_M1) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Stall watchdog only runs while the bus is owned; any transfer restarts it.
      if (tx_active) begin
         if (xfer) begin
            stall_d = 16'd0;
         end else if ((TIMEOUT > 0) && (stall_q == TO_M1)) begin
            abort_d  = 1'b1;
            stall_d  = 16'd0;
            data_d   = 8'd0;
            vld_d    = 1'b0;
            cnt_d    = 6'd0;
            rd_ptr_d = 6'd0;
            state_d  = S_IDLE;
         end else begin
            stall_d = stall_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[cnt_q] <= ld_data;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= 6'd0;
         rd_ptr_q <= 6'd0;
         len_q    <= 6'd0;
         parity_q <= 8'd0;
         data_q   <= 8'd0;
         vld_q    <= 1'b0;
         stall_q  <= 16'd0;
         gap_q    <= 8'd0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_ptr_q <= rd_ptr_d;
         len_q    <= len_d;
         parity_q <= parity_d;
         data_q   <= data_d;
         vld_q    <= vld_d;
         stall_q  <= stall_d;
         gap_q    <= gap_d;
         done_q   <= done_d;
         err_q    <= err_d;
         abort_q  <= abort_d;
      end
   end

   assign data_out  = data_q;
   assign pkt_valid = vld_q;
   assign tx_done   = done_q;
   assign start_err = err_q;
   assign tx_abort  = abort_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: two instances (TIMEOUT=8 and TIMEOUT=0) share stimulus; bus bytes scored per instance.
module tb_router_pkt_tx;

   logic       clock = 1'b0;
   logic       resetn = 1'b1;
   logic       ld_en = 1'b0;
   logic [7:0] ld_data = 8'd0;
   logic       start = 1'b0;
   logic [1:0] dest_addr = 2'd0;
   logic       busy = 1'b0;

   logic       a_ld_rdy, a_pkt_valid, a_tx_active, a_tx_done, a_start_err, a_tx_abort;
   logic [7:0] a_data_out;
   logic       b_ld_rdy, b_pkt_valid, b_tx_active, b_tx_done, b_start_err, b_tx_abort;
   logic [7:0] b_data_out;

   router_pkt_tx #(.GAP_CYCLES(2), .TIMEOUT(8)) u_dut (
      .clock(clock), .resetn(resetn), .ld_en(ld_en), .ld_data(ld_data), .ld_rdy(a_ld_rdy),
      .start(start), .dest_addr(dest_addr), .busy(busy), .data_out(a_data_out),
      .pkt_valid(a_pkt_valid), .tx_active(a_tx_active), .tx_done(a_tx_done),
      .start_err(a_start_err), .tx_abort(a_tx_abort)
   );

   router_pkt_tx u_dut_noto (
      .clock(clock), .resetn(resetn), .ld_en(ld_en), .ld_data(ld_data), .ld_rdy(b_ld_rdy),
      .start(start), .dest_addr(dest_addr), .busy(busy), .data_out(b_data_out),
      .pkt_valid(b_pkt_valid), .tx_active(b_tx_active), .tx_done(b_tx_done),
      .start_err(b_start_err), .tx_abort(b_tx_abort)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   logic [8:0] q_a[$];
   logic [8:0] q_b[$];
   logic [7:0] pl_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic load(input logic [7:0] b);
      ld_data = b;
      ld_en   = 1'b1;
      cyc(1);
      ld_en   = 1'b0;
   endtask

   // Expected bus stream for the payload in pl_q: header, bytes, then parity with pkt_valid low.
   task automatic push_pkt(input logic [1:0] addr, input bit to_b);
      logic [7:0] hdr;
      logic [7:0] par;
      hdr = {6'(pl_q.size()), addr};
      par = hdr;
      q_a.push_back({1'b1, hdr});
      if (to_b) q_b.push_back({1'b1, hdr});
      foreach (pl_q[i]) begin
         par ^= pl_q[i];
         q_a.push_back({1'b1, pl_q[i]});
         if (to_b) q_b.push_back({1'b1, pl_q[i]});
      end
      q_a.push_back({1'b0, par});
      if (to_b) q_b.push_back({1'b0, par});
   endtask

   task automatic send(input logic [1:0] addr);
      push_pkt(addr, 1'b1);
      dest_addr = addr;
      start     = 1'b1;
      cyc(1);
      start     = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (a_tx_done !== 1'b1 && n < 300) begin
         cyc(1);
         n++;
      end
      check("done_seen", a_tx_done, 1);
   endtask

   // A byte presented with busy low moves on the next rising edge.
   always @(negedge clock) begin
      if (resetn && a_tx_active && !busy) begin
         if (q_a.size() == 0) check("a_extra_byte", {a_pkt_valid, a_data_out}, 9'h000);
         else check("a_bus", {a_pkt_valid, a_data_out}, q_a.pop_front());
      end
   end

   always @(negedge clock) begin
      if (resetn && b_tx_active && !busy) begin
         if (q_b.size() == 0) check("b_extra_byte", {b_pkt_valid, b_data_out}, 9'h000);
         else check("b_bus", {b_pkt_valid, b_data_out}, q_b.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      #1 resetn = 1'b0;
      #3;
      check("rst_data", a_data_out, 8'h00);
      check("rst_vld", a_pkt_valid, 0);
      check("rst_active", a_tx_active, 0);
      check("rst_done", a_tx_done, 0);
      check("rst_err", a_start_err, 0);
      check("rst_abort", a_tx_abort, 0);
      check("rst_ldrdy", a_ld_rdy, 1);
      @(negedge clock) resetn = 1'b1;
      cyc(1);

      // Basic packet, then GAP behaviour.
      load(8'h11); load(8'h22); load(8'h33);
      pl_q = {8'h11, 8'h22, 8'h33};
      send(2'd1);
      check("t1_hdr", a_data_out, 8'h0D);
      check("t1_hvld", a_pkt_valid, 1);
      check("t1_ldrdy_tx", a_ld_rdy, 0);
      wait_done(n);
      check("t1_len_plus2", n, 5);
      check("t1_data_after", a_data_out, 8'h00);
      check("t1_ldrdy_gap0", a_ld_rdy, 0);
      dest_addr = 2'd1;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      check("t1_done_pulse", a_tx_done, 0);
      check("t1_gap_noerr", a_start_err, 0);
      check("t1_ldrdy_gap1", a_ld_rdy, 0);
      cyc(1);
      check("t1_ldrdy_idle", a_ld_rdy, 1);

      // Busy stall after the header.
      load(8'h11); load(8'h22); load(8'h33);
      send(2'd1);
      cyc(1);
      busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         check("t2_hold_data", a_data_out, 8'h11);
         check("t2_hold_vld", a_pkt_valid, 1);
      end
      busy = 1'b0;
      wait_done(n);
      check("t2_tail_cycles", n, 4);
      check("t2_no_abort", a_tx_abort, 0);
      cyc(3);

      // Rejected starts; rejected start with same-cycle load still loads.
      dest_addr = 2'd1;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      check("t3_err_empty", a_start_err, 1);
      check("t3_idle_empty", a_tx_active, 0);
      cyc(1);
      check("t3_err_pulse", a_start_err, 0);
      load(8'hAA); load(8'hBB);
      dest_addr = 2'd3;
      start = 1'b1;
      ld_data = 8'hCC;
      ld_en = 1'b1;
      cyc(1);
      start = 1'b0;
      ld_en = 1'b0;
      check("t3_err_addr3", a_start_err, 1);
      check("t3_vld_low", a_pkt_valid, 0);

      // Fill to 63, 64th load ignored, full-length packet.
      pl_q = {8'hAA, 8'hBB, 8'hCC};
      for (int i = 3; i < 63; i++) begin
         load(8'(i * 3 + 1));
         pl_q.push_back(8'(i * 3 + 1));
      end
      check("t4_ldrdy_full", a_ld_rdy, 0);
      load(8'hEE);
      send(2'd2);
      check("t4_hdr", a_data_out, 8'hFE);
      wait_done(n);
      check("t4_len_plus2", n, 65);
      cyc(3);

      // Start accepted together with a load: the load is dropped.
      load(8'h44);
      pl_q = {8'h44};
      push_pkt(2'd0, 1'b1);
      dest_addr = 2'd0;
      start = 1'b1;
      ld_data = 8'h55;
      ld_en = 1'b1;
      cyc(1);
      start = 1'b0;
      ld_en = 1'b0;
      check("t7_hdr", a_data_out, 8'h04);
      wait_done(n);
      check("t7_len_plus2", n, 3);
      cyc(3);

      // Asynchronous reset mid-payload.
      pl_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      foreach (pl_q[i]) load(pl_q[i]);
      send(2'd0);
      cyc(3);
      #2 resetn = 1'b0;
      #1;
      check("t5_vld_async", a_pkt_valid, 0);
      check("t5_data_async", a_data_out, 8'h00);
      check("t5_active_async", a_tx_active, 0);
      q_a.delete();
      q_b.delete();
      @(negedge clock) resetn = 1'b1;
      cyc(1);
      check("t5_ldrdy", a_ld_rdy, 1);
      dest_addr = 2'd0;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      check("t5_count_zero", a_start_err, 1);
      cyc(1);

      // Busy stuck from the header: abort after 8 stalls on the TIMEOUT=8 instance only.
      load(8'h5A); load(8'hA5);
      pl_q = {8'h5A, 8'hA5};
      push_pkt(2'd1, 1'b1);
      dest_addr = 2'd1;
      start = 1'b1;
      busy = 1'b1;
      cyc(1);
      start = 1'b0;
      check("t6_hdr", a_data_out, 8'h09);
      for (int i = 1; i < 8; i++) begin
         cyc(1);
         check("t6_no_abort_yet", a_tx_abort, 0);
      end
      cyc(1);
      check("t6_abort", a_tx_abort, 1);
      check("t6_abort_vld", a_pkt_valid, 0);
      check("t6_abort_data", a_data_out, 8'h00);
      check("t6_abort_idle", a_ld_rdy, 1);
      check("t6_noto_vld", b_pkt_valid, 1);
      check("t6_noto_abort", b_tx_abort, 0);
      q_a.delete();
      load(8'h77);
      check("t6_abort_pulse", a_tx_abort, 0);
      pl_q = {8'h77};
      push_pkt(2'd2, 1'b0);
      dest_addr = 2'd2;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      check("t6_restart_hdr", a_data_out, 8'h06);
      check("t6_restart_active", a_tx_active, 1);
      busy = 1'b0;
      wait_done(n);
      check("t6_restart_len", n, 3);
      cyc(4);
      check("end_q_a_empty", q_a.size(), 0);
      check("end_q_b_empty", q_b.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
